mem_stage_lsu: RTL and testbench

// MEM-stage load/store unit; consumes the EX/MEM register outputs (control, ALU address, store data, funct3).

---
 rtl/mem_stage_lsu.sv | 162 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a req/ack data-memory transaction, stalls the
// pipeline until it completes, and formats store strobes/data and load results.
module mem_stage_lsu #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_memRead,
   input  logic                  mem_memWrite,
   input  logic [31:0]           mem_ALUResult,
   input  logic [31:0]           mem_readData2,
   input  logic [2:0]            mem_funct3,
   output logic                  mem_stall,
   output logic [31:0]           mem_loadData,
   output logic                  mem_misaligned,
   output logic                  mem_busErr,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [31:0]           dmem_wdata,
   output logic [3:0]            dmem_wstrb,
   input  logic                  dmem_ack,
   input  logic [31:0]           dmem_rdata
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       off_q;
   logic [2:0]       f3_q;

   logic             access_d;
   logic             store_d;
   logic             legal_d;
   logic [31:0]      wdata_d;
   logic [3:0]       wstrb_d;
   logic [31:0]      lane_d;
   logic [31:0]      ext_d;

   // Decode of the access presented by EX/MEM: legality, strobes, replicated data.
   always_comb begin
      access_d = mem_memRead | mem_memWrite;
      store_d  = mem_memWrite;
      legal_d  = 1'b0;
      case (mem_funct3)
         3'b000:  legal_d = 1'b1;
         3'b001:  legal_d = ~mem_ALUResult[0];
         3'b010:  legal_d = (mem_ALUResult[1:0] == 2'b00);
         3'b100:  legal_d = ~store_d;
         3'b101:  legal_d = ~store_d & ~mem_ALUResult[0];
         default: legal_d = 1'b0;
      endcase

      wdata_d = mem_readData2;
      wstrb_d = 4'b1111;
      case (mem_funct3[1:0])
         2'b00: begin
            wdata_d = {4{mem_readData2[7:0]}};
            wstrb_d = 4'b0001 << mem_ALUResult[1:0];
         end
         2'b01: begin
            wdata_d = {2{mem_readData2[15:0]}};
            wstrb_d = 4'b0011 << mem_ALUResult[1:0];
         end
         default: ;
      endcase
      if (!store_d) begin
         wstrb_d = 4'b0000;
      end
   end

   // Load formatting uses the offset/size captured at request time.
   always_comb begin
      lane_d = dmem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ext_d = {{24{lane_d[7]}}, lane_d[7:0]};
         3'b001:  ext_d = {{16{lane_d[15]}}, lane_d[15:0]};
         3'b100:  ext_d = {24'h000000, lane_d[7:0]};
         3'b101:  ext_d = {16'h0000, lane_d[15:0]};
         default: ext_d = lane_d;
      endcase
   end

   always_comb begin
      mem_stall      = 1'b0;
      mem_misaligned = 1'b0;
      case (state_q)
         S_IDLE: begin
            mem_stall      = access_d & legal_d;
            mem_misaligned = access_d & ~legal_d;
         end
         S_BUSY:  mem_stall = 1'b1;
         default: ;
      endcase
   end

   // Transaction FSM; DONE always returns to IDLE so an unchanged EX/MEM is not reissued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         off_q        <= 2'b00;
         f3_q         <= 3'b000;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= 32'h0;
         dmem_wstrb   <= 4'b0000;
         mem_loadData <= 32'h0;
         mem_busErr   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (access_d && legal_d) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= store_d;
                  dmem_addr  <= {mem_ALUResult[ADDR_WIDTH-1:2], 2'b00};
                  dmem_wdata <= wdata_d;
                  dmem_wstrb <= wstrb_d;
                  off_q      <= mem_ALUResult[1:0];
                  f3_q       <= mem_funct3;
                  cnt_q      <= '0;
                  state_q    <= S_BUSY;
               end else if (access_d) begin
                  mem_loadData <= 32'h0;
                  mem_busErr   <= 1'b0;
               end
            end
            S_BUSY: begin
               if (dmem_ack) begin
                  dmem_req     <= 1'b0;
                  dmem_we      <= 1'b0;
                  dmem_wstrb   <= 4'b0000;
                  mem_loadData <= dmem_we ? 32'h0 : ext_d;
                  mem_busErr   <= 1'b0;
                  state_q      <= S_DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  dmem_req     <= 1'b0;
                  dmem_we      <= 1'b0;
                  dmem_wstrb   <= 4'b0000;
                  mem_loadData <= 32'h0;
                  mem_busErr   <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized and directed bench for mem_stage_lsu against a byte-level reference model.
module tb_mem_stage_lsu;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_memRead, mem_memWrite;
   logic [31:0] mem_ALUResult, mem_readData2;
   logic [2:0]  mem_funct3;
   logic        mem_stall, mem_misaligned, mem_busErr;
   logic [31:0] mem_loadData;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;

   int vecs = 0;
   int errs = 0;

   mem_stage_lsu #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
      .mem_ALUResult(mem_ALUResult), .mem_readData2(mem_readData2),
      .mem_funct3(mem_funct3), .mem_stall(mem_stall),
      .mem_loadData(mem_loadData), .mem_misaligned(mem_misaligned),
      .mem_busErr(mem_busErr), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   // Reference: accesses described as byte ranges within the addressed word.
   function automatic void model(input logic wr, input logic [31:0] a, d, rdata,
                                 input logic [2:0] f3, output logic legal,
                                 output logic [3:0] strb, output logic [31:0] wd,
                                 output logic [31:0] ld);
      int size;
      int off;
      logic [31:0] mask;
      logic [31:0] v;
      off  = int'(a[1:0]);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (wr) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
      else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      legal = legal && ((off % size) == 0);
      strb = 4'b0000;
      wd   = 32'h0;
      for (int b = 0; b < 4; b++) begin
         if (wr && b >= off && b < off + size) strb[b] = 1'b1;
         wd[8*b +: 8] = d[8*(b % size) +: 8];
      end
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 32'h1);
      v = (rdata >> (8*off)) & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      ld = wr ? 32'h0 : v;
   endfunction

   task automatic clear_inputs();
      mem_memRead   = 1'b0;
      mem_memWrite  = 1'b0;
      mem_ALUResult = $urandom;
      mem_readData2 = $urandom;
      mem_funct3    = 3'($urandom_range(0, 7));
   endtask

   // One access from IDLE; called and returns at posedge+1.
   task automatic do_access(input logic rd, wr, input logic [31:0] a, d,
                            input logic [2:0] f3, input int waits, input logic [31:0] rdata,
                            input string tag);
      logic        legal;
      logic [3:0]  strb;
      logic [31:0] wd, ld;
      int          stalls;
      model(wr, a, d, rdata, f3, legal, strb, wd, ld);
      mem_memRead = rd; mem_memWrite = wr; mem_ALUResult = a;
      mem_readData2 = d; mem_funct3 = f3;
      @(negedge clk);
      vecs++;
      if (mem_misaligned !== !legal) begin
         errs++; $display("FAIL %s misaligned: got %b want %b", tag, mem_misaligned, !legal);
      end
      vecs++;
      if (mem_stall !== legal) begin
         errs++; $display("FAIL %s present_stall: got %b want %b", tag, mem_stall, legal);
      end
      if (!legal) begin
         @(posedge clk); #1;
         vecs++;
         if (dmem_req !== 1'b0 || mem_loadData !== 32'h0 || mem_busErr !== 1'b0) begin
            errs++; $display("FAIL %s illegal_result: req %b ld %h berr %b want 0 0 0",
                             tag, dmem_req, mem_loadData, mem_busErr);
         end
         clear_inputs();
         return;
      end
      stalls = 1;
      @(posedge clk); #1;
      vecs++;
      if (dmem_req !== 1'b1 || dmem_we !== wr || dmem_addr !== (a & ~32'h3) ||
          dmem_wstrb !== strb || (wr && dmem_wdata !== wd)) begin
         errs++;
         $display("FAIL %s request: req %b we %b addr %h strb %b wd %h want 1 %b %h %b %h",
                  tag, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
                  wr, a & ~32'h3, strb, wd);
      end
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         if (mem_stall === 1'b1) stalls++;
         @(posedge clk); #1;
         vecs++;
         if (dmem_req !== 1'b1 || dmem_addr !== (a & ~32'h3) || dmem_wstrb !== strb) begin
            errs++; $display("FAIL %s hold: req %b addr %h strb %b want 1 %h %b",
                             tag, dmem_req, dmem_addr, dmem_wstrb, a & ~32'h3, strb);
         end
      end
      dmem_ack = 1'b1; dmem_rdata = rdata;
      @(negedge clk);
      if (mem_stall === 1'b1) stalls++;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      @(negedge clk);
      vecs++;
      if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
         errs++; $display("FAIL %s done: stall %b req %b want 0 0", tag, mem_stall, dmem_req);
      end
      vecs++;
      if (stalls != waits + 2) begin
         errs++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, waits + 2);
      end
      vecs++;
      if (mem_loadData !== ld || mem_busErr !== 1'b0) begin
         errs++; $display("FAIL %s load_data: got %h berr %b want %h 0",
                          tag, mem_loadData, mem_busErr, ld);
      end
      @(posedge clk); #1;
      vecs++;
      if (dmem_req !== 1'b0) begin
         errs++; $display("FAIL %s reissue: req %b want 0", tag, dmem_req);
      end
      clear_inputs();
   endtask

   task automatic test_reset();
      rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      vecs++;
      if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0 ||
          dmem_wdata !== 32'h0 || dmem_wstrb !== 4'h0 || mem_loadData !== 32'h0 ||
          mem_busErr !== 1'b0 || mem_stall !== 1'b0 || mem_misaligned !== 1'b0) begin
         errs++; $display("FAIL reset_state: req %b addr %h ld %h berr %b stall %b",
                          dmem_req, dmem_addr, mem_loadData, mem_busErr, mem_stall);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      do_access(1, 0, 32'h100, 32'h0, 3'b010, 0, 32'hDEADBEEF, "lw_zero_wait");
      do_access(1, 0, 32'h103, 32'h0, 3'b000, 1, 32'h80FFFFFF, "lb_sext");
      do_access(1, 0, 32'h103, 32'h0, 3'b100, 0, 32'h80FFFFFF, "lbu_zext");
      do_access(1, 0, 32'h102, 32'h0, 3'b101, 2, 32'h80FFFFFF, "lhu_zext");
      do_access(1, 0, 32'h102, 32'h0, 3'b001, 0, 32'h80FFFFFF, "lh_sext");
      do_access(0, 1, 32'h206, 32'h1234ABCD, 3'b001, 3, 32'h0, "sh_3wait");
      do_access(1, 1, 32'h301, 32'hA5A5_5AC3, 3'b000, 0, 32'hFFFF_FFFF, "sb_both_set");
   endtask

   task automatic test_illegal();
      do_access(1, 0, 32'h1234, 32'h0, 3'b010, 0, 32'h7777_7777, "pre_illegal");
      do_access(1, 0, 32'h101, 32'h0, 3'b010, 0, 32'h0, "lw_misaligned");
      do_access(0, 1, 32'h003, 32'h0, 3'b001, 0, 32'h0, "sh_misaligned");
      do_access(1, 0, 32'h100, 32'h0, 3'b011, 0, 32'h0, "funct3_011");
      do_access(0, 1, 32'h100, 32'h0, 3'b100, 0, 32'h0, "store_bu");
   endtask

   task automatic test_timeout();
      int req_cycles;
      mem_memRead = 1'b1; mem_memWrite = 1'b0;
      mem_ALUResult = 32'h440; mem_funct3 = 3'b010;
      @(posedge clk); #1;
      req_cycles = 0;
      while (dmem_req === 1'b1 && req_cycles < 20) begin
         req_cycles++;
         @(posedge clk); #1;
      end
      vecs++;
      if (req_cycles != TO) begin
         errs++; $display("FAIL timeout_req_cycles: got %0d want %0d", req_cycles, TO);
      end
      vecs++;
      if (mem_busErr !== 1'b1 || mem_loadData !== 32'h0 || mem_stall !== 1'b0) begin
         errs++; $display("FAIL timeout_done: berr %b ld %h stall %b want 1 0 0",
                          mem_busErr, mem_loadData, mem_stall);
      end
      clear_inputs();
      @(posedge clk); #1;
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(posedge clk); #1;
      vecs++;
      if (dmem_req !== 1'b0 || mem_busErr !== 1'b1 || mem_loadData !== 32'h0) begin
         errs++; $display("FAIL late_ack: req %b berr %b ld %h want 0 1 0",
                          dmem_req, mem_busErr, mem_loadData);
      end
   endtask

   task automatic test_reset_mid_busy();
      mem_memRead = 1'b1; mem_memWrite = 1'b0;
      mem_ALUResult = 32'h500; mem_funct3 = 3'b010;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      vecs++;
      if (dmem_req !== 1'b0) begin
         errs++; $display("FAIL reset_busy_req: got %b want 0", dmem_req);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_inputs();
      dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      vecs++;
      if (dmem_req !== 1'b0 || mem_loadData !== 32'h0 || mem_stall !== 1'b0) begin
         errs++; $display("FAIL reset_ack_ignored: req %b ld %h stall %b want 0 0 0",
                          dmem_req, mem_loadData, mem_stall);
      end
      do_access(1, 0, 32'h600, 32'h0, 3'b010, 1, 32'h2468_ACE0, "lw_after_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int unsigned r;
         r = $urandom_range(1, 3);
         do_access(r[0], r[1], $urandom, $urandom, 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, TO - 2)), $urandom, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_illegal();
      test_timeout();
      test_reset_mid_busy();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
